// File: rtl/seq_scan_ctrl.sv
// Serial pattern scanner: shifts a captured word out MSB-first and counts
// (possibly overlapping) occurrences of a captured bit pattern.
module seq_scan_ctrl #(
  parameter int WORD_W = 8,
  parameter int PAT_W  = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [WORD_W-1:0]         data_in,
  input  logic [PAT_W-1:0]          pattern,
  output logic                      b,
  output logic                      busy,
  output logic                      hit,
  output logic                      done,
  output logic [$clog2(WORD_W):0]   match_cnt,
  output logic [2:0]                debug
);

  localparam int CNT_W = $clog2(WORD_W);
  localparam int MC_W  = CNT_W + 1;
  localparam logic [CNT_W-1:0] LastBit  = CNT_W'(WORD_W - 1);
  localparam logic [CNT_W-1:0] FirstWin = CNT_W'(PAT_W - 1);
  localparam logic [CNT_W-1:0] NextBase = CNT_W'(WORD_W - 2);

  typedef enum logic [2:0] {
    StIdle  = 3'b000,
    StShift = 3'b001,
    StDone  = 3'b010
  } state_e;

  state_e              r_state;
  logic [WORD_W-1:0]   r_data;
  logic [PAT_W-1:0]    r_pat;
  logic [CNT_W-1:0]    r_bcnt;
  logic [PAT_W-2:0]    r_hist;
  logic [MC_W-1:0]     r_mcnt;
  logic                r_b;
  logic                r_hit;

  logic [PAT_W-1:0]    w_window;
  logic [CNT_W-1:0]    w_next_idx;
  logic                w_match;

  assign w_window   = {r_hist, r_b};
  // Index of the bit presented in the next SHIFT cycle.
  assign w_next_idx = NextBase - r_bcnt;
  assign w_match    = (r_state == StShift) && (r_bcnt >= FirstWin) && (w_window == r_pat);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= StIdle;
      r_data  <= '0;
      r_pat   <= '0;
      r_bcnt  <= '0;
      r_hist  <= '0;
      r_mcnt  <= '0;
      r_b     <= 1'b0;
      r_hit   <= 1'b0;
    end else begin
      r_hit <= 1'b0;
      case (r_state)
        StIdle: begin
          if (start) begin
            r_data  <= data_in;
            r_pat   <= pattern;
            r_bcnt  <= '0;
            r_hist  <= '0;
            r_mcnt  <= '0;
            r_b     <= data_in[WORD_W-1];
            r_state <= StShift;
          end
        end
        StShift: begin
          r_hist <= w_window[PAT_W-2:0];
          if (w_match) begin
            r_hit  <= 1'b1;
            r_mcnt <= r_mcnt + MC_W'(1);
          end
          if (r_bcnt == LastBit) begin
            r_b     <= 1'b0;
            r_state <= StDone;
          end else begin
            r_b    <= r_data[w_next_idx];
            r_bcnt <= r_bcnt + CNT_W'(1);
          end
        end
        StDone: begin
          r_state <= StIdle;
        end
        default: begin
          r_b     <= 1'b0;
          r_state <= StIdle;
        end
      endcase
    end
  end

  assign b         = r_b;
  assign busy      = (r_state == StShift);
  assign done      = (r_state == StDone);
  assign hit       = r_hit;
  assign match_cnt = r_mcnt;
  assign debug     = r_state;

endmodule

// File: tb/tb_seq_scan_ctrl.sv
// Directed bench for seq_scan_ctrl (WORD_W=8, PAT_W=4) with hand-computed expectations.
module tb_seq_scan_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic [7:0] data_in;
  logic [3:0] pattern;
  logic       b;
  logic       busy;
  logic       hit;
  logic       done;
  logic [3:0] match_cnt;
  logic [2:0] debug;

  int n_err = 0;
  int n_chk = 0;

  seq_scan_ctrl #(.WORD_W(8), .PAT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .data_in   (data_in),
    .pattern   (pattern),
    .b         (b),
    .busy      (busy),
    .hit       (hit),
    .done      (done),
    .match_cnt (match_cnt),
    .debug     (debug)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // exp_hit bit c is the expected hit in absolute cycle c after the accepting edge.
  task automatic run_scan(input logic [7:0] d, input logic [3:0] p, input logic [9:0] exp_hit,
                          input logic [3:0] exp_cnt, input bit hold);
    start   = 1'b1;
    data_in = d;
    pattern = p;
    tick();
    if (!hold) start = 1'b0;
    check_val("cnt_cleared", match_cnt, 0);
    for (int c = 1; c <= 8; c++) begin
      check_val($sformatf("busy_c%0d", c), busy, 1);
      check_val($sformatf("dbg_shift_c%0d", c), debug, 3'b001);
      check_val($sformatf("b_c%0d", c), b, d[8-c]);
      check_val($sformatf("hit_c%0d", c), hit, exp_hit[c]);
      check_val($sformatf("done_lo_c%0d", c), done, 0);
      if (hold) begin
        data_in = 8'($urandom);
        pattern = 4'($urandom);
      end
      tick();
    end
    check_val("done_pulse", done, 1);
    check_val("dbg_done", debug, 3'b010);
    check_val("busy_done", busy, 0);
    check_val("b_done", b, 0);
    check_val("hit_c9", hit, exp_hit[9]);
    check_val("cnt_at_done", match_cnt, exp_cnt);
    tick();
    check_val("dbg_idle", debug, 3'b000);
    check_val("done_idle", done, 0);
    check_val("hit_idle", hit, 0);
    check_val("cnt_hold", match_cnt, exp_cnt);
  endtask

  // Abort an 8'hFF/4'hF scan by reset in absolute cycle at_cycle (1..9).
  task automatic abort_scan(input int at_cycle);
    start   = 1'b1;
    data_in = 8'hFF;
    pattern = 4'hF;
    tick();
    start = 1'b0;
    repeat (at_cycle - 1) tick();
    rst   = 1'b1;
    start = 1'b1;
    tick();
    check_val("abort_dbg", debug, 3'b000);
    check_val("abort_cnt", match_cnt, 0);
    check_val("abort_busy", busy, 0);
    check_val("abort_done", done, 0);
    check_val("abort_hit", hit, 0);
    check_val("abort_b", b, 0);
    rst   = 1'b0;
    start = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("post_abort_done", done, 0);
      check_val("post_abort_dbg", debug, 3'b000);
    end
  endtask

  initial begin
    rst     = 1'b1;
    start   = 1'b1;
    data_in = 8'hA5;
    pattern = 4'h5;
    tick();
    tick();
    check_val("rst_dbg", debug, 3'b000);
    check_val("rst_b", b, 0);
    check_val("rst_busy", busy, 0);
    check_val("rst_hit", hit, 0);
    check_val("rst_done", done, 0);
    check_val("rst_cnt", match_cnt, 0);
    rst   = 1'b0;
    start = 1'b0;
    tick();
    check_val("idle_no_start", debug, 3'b000);

    run_scan(8'b1011_0110, 4'b0110, 10'h240, 4'd2, 1'b0);
    run_scan(8'hFF, 4'hF, 10'h3E0, 4'd5, 1'b0);
    run_scan(8'h00, 4'hF, 10'h000, 4'd0, 1'b0);
    // Early window must not match against the cleared history.
    run_scan(8'b1000_0000, 4'b0001, 10'h000, 4'd0, 1'b0);
    // start held high with noisy inputs, then back-to-back scans.
    run_scan(8'b1010_1010, 4'b1010, 10'h2A0, 4'd3, 1'b1);
    run_scan(8'b0110_0110, 4'b0110, 10'h220, 4'd2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("cnt_hold_idle", match_cnt, 2);
    end

    abort_scan(4);
    abort_scan(6);
    abort_scan(9);
    run_scan(8'hFF, 4'hF, 10'h3E0, 4'd5, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
